// File: rtl/axi_bridge_mc.sv
// axi_bridge_mc: multi-channel cache-to-AXI3 bridge with one outstanding read, a write FIFO,
// and read stalls while a buffered write to the same line is pending.
module axi_bridge_mc #(
  parameter int N_CH       = 2,
  parameter int LINE_WORDS = 4,
  parameter int WB_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         rd_req,
  input  logic [3*N_CH-1:0]       rd_type,
  input  logic [32*N_CH-1:0]      rd_addr,
  output logic [N_CH-1:0]         rd_rdy,
  output logic [N_CH-1:0]         ret_valid,
  output logic                    ret_last,
  output logic [31:0]             ret_data,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    write_buffer_empty,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [3:0]              wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);
  localparam int OFF = $clog2(4 * LINE_WORDS);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int PW  = WB_DEPTH > 1 ? $clog2(WB_DEPTH) : 1;
  localparam int CW  = N_CH > 1 ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} w_state_e;
  r_state_e r_q, r_d;
  w_state_e w_q, w_d;
  logic [CW-1:0] lg_q, ch_q, gnt;
  logic [31:0] raddr_q, gaddr;
  logic [2:0] rtype_q;
  logic gnt_vld, hazard, rline, wline, fin, push, pop, unused_ok;
  logic [31:0] wb_addr_q [WB_DEPTH];
  logic [2:0] wb_type_q [WB_DEPTH];
  logic [3:0] wb_strb_q [WB_DEPTH];
  logic [32*LINE_WORDS-1:0] wb_data_q [WB_DEPTH];
  logic [WB_DEPTH-1:0] vld_q;
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q;
  logic [BW-1:0] beat_q;
  assign unused_ok = ^{rid, rresp, bid, bresp};
  // descending scan so the nearest requester after last grant wins
  always_comb begin
    gnt = lg_q;
    gnt_vld = 1'b0;
    for (int i = N_CH; i >= 1; i--)
      if (rd_req[(int'(lg_q) + i) % N_CH]) begin
        gnt = CW'((int'(lg_q) + i) % N_CH);
        gnt_vld = 1'b1;
      end
  end
  assign gaddr = rd_addr[32*int'(gnt) +: 32];
  // hazard uses registered entries only, so a same-cycle push never blocks the read
  always_comb begin
    hazard = 1'b0;
    for (int e = 0; e < WB_DEPTH; e++)
      if (vld_q[e] && wb_addr_q[e][31:OFF] == gaddr[31:OFF]) hazard = 1'b1;
  end
  assign rd_rdy = (!reset && r_q == R_IDLE && gnt_vld && !hazard) ? N_CH'(1) << gnt : '0;
  assign r_d = r_q == R_IDLE ? (|rd_rdy ? R_AR : R_IDLE) :
               r_q == R_AR   ? (arready ? R_DATA : R_AR) :
               r_q == R_DATA ? ((rvalid && rlast) ? R_IDLE : R_DATA) : R_IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= R_IDLE;
      lg_q <= CW'(N_CH - 1);
    end else begin
      r_q <= r_d;
      if (|rd_rdy) begin
        lg_q <= gnt;
        ch_q <= gnt;
        raddr_q <= gaddr;
        rtype_q <= rd_type[3*int'(gnt) +: 3];
      end
    end
  end
  assign rline = rtype_q == 3'b100;
  assign arid = 4'(ch_q);
  assign araddr = rline ? {raddr_q[31:OFF], {OFF{1'b0}}} : raddr_q;
  assign arlen = rline ? 8'(LINE_WORDS - 1) : 8'd0;
  assign arsize = rline ? 3'd2 : {1'b0, rtype_q[1:0]};
  assign arburst = 2'b01;
  assign arlock = '0;
  assign arcache = '0;
  assign arprot = '0;
  assign arvalid = !reset && r_q == R_AR;
  assign rready = !reset && r_q == R_DATA;
  assign ret_valid = (rready && rvalid) ? N_CH'(1) << ch_q : '0;
  assign ret_last = rready && rlast;
  assign ret_data = rdata;
  assign wr_rdy = !reset && cnt_q < (PW+1)'(WB_DEPTH);
  assign write_buffer_empty = reset || cnt_q == '0;
  assign push = wr_req && wr_rdy;
  assign pop = w_q == W_B && bvalid;
  assign wline = wb_type_q[rp_q] == 3'b100;
  assign fin = wline ? beat_q == BW'(LINE_WORDS - 1) : 1'b1;
  assign w_d = w_q == W_IDLE ? (cnt_q != '0 ? W_AW : W_IDLE) :
               w_q == W_AW   ? (awready ? W_DATA : W_AW) :
               w_q == W_DATA ? ((wready && fin) ? W_B : W_DATA) :
               bvalid ? W_IDLE : W_B;
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q <= W_IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      vld_q <= '0;
      beat_q <= '0;
    end else begin
      w_q <= w_d;
      if (push) begin
        wb_addr_q[wp_q] <= wr_addr;
        wb_type_q[wp_q] <= wr_type;
        wb_strb_q[wp_q] <= wr_wstrb;
        wb_data_q[wp_q] <= wr_data;
        vld_q[wp_q] <= 1'b1;
        wp_q <= wp_q == PW'(WB_DEPTH - 1) ? '0 : wp_q + 1'b1;
      end
      if (pop) begin
        vld_q[rp_q] <= 1'b0;
        rp_q <= rp_q == PW'(WB_DEPTH - 1) ? '0 : rp_q + 1'b1;
      end
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      if (w_q == W_DATA && wready) beat_q <= fin ? '0 : beat_q + 1'b1;
    end
  end
  assign awid = 4'd1;
  assign awaddr = wline ? {wb_addr_q[rp_q][31:OFF], {OFF{1'b0}}} : wb_addr_q[rp_q];
  assign awlen = wline ? 8'(LINE_WORDS - 1) : 8'd0;
  assign awsize = wline ? 3'd2 : {1'b0, wb_type_q[rp_q][1:0]};
  assign awburst = 2'b01;
  assign awlock = '0;
  assign awcache = '0;
  assign awprot = '0;
  assign awvalid = !reset && w_q == W_AW;
  assign wid = 4'd1;
  assign wdata = wb_data_q[rp_q][32*int'(beat_q) +: 32];
  assign wstrb = wline ? 4'hF : wb_strb_q[rp_q];
  assign wlast = fin;
  assign wvalid = !reset && w_q == W_DATA;
  assign bready = !reset && w_q == W_B;
endmodule
